ctrl_pipe_chain: RTL and testbench

- Parametrised control-signal pipeline; successor to the fixed E/M/W control register chain in the core controller.
- Carries a W-bit decoded control bundle from decode through STAGES registered stages.
- Per-stage stall (hold), flush (clear) and valid tracking, plus a per-stage keep mask that narrows the bundle as it moves down the pipe.
- Inserts all-zero bubbles automatically when an upstream stage is held, and reports occupancy and a bubble count for performance debug.

---
 rtl/ctrl_pipe_chain.sv | 114 +++++++++++
 tb/tb_ctrl_pipe_chain.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_chain.sv
// Parametrised control-bundle pipeline with per-stage stall, flush, valid and keep mask.
// Upstream stalls insert zero bubbles downstream; a saturating counter tracks them.
module ctrl_pipe_chain #(
  parameter int                    W         = 18,
  parameter int                    STAGES    = 3,
  parameter logic [STAGES*W-1:0]   KEEP_MASK = {STAGES*W{1'b1}},
  parameter int                    CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [W-1:0]                  in_ctrl,
  input  logic [STAGES-1:0]             stall,
  input  logic [STAGES-1:0]             flush,
  output logic                          in_ready,
  output logic [STAGES*W-1:0]           out_ctrl,
  output logic [STAGES-1:0]             out_valid,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              bubble_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);
  localparam int SUM_W = CNT_W + 4;
  localparam logic [SUM_W-1:0] CNT_MAX = {{4{1'b0}}, {CNT_W{1'b1}}};

  logic [STAGES-1:0]     hold_s;
  logic [STAGES:0]       hold_ext_s;
  logic [STAGES:0]       valid_ext_s;
  logic [(STAGES+1)*W-1:0] ctrl_ext_s;
  logic [STAGES-1:0]     bubble_s;
  logic [STAGES-1:0]     valid_d, valid_q;
  logic [STAGES*W-1:0]   ctrl_d, ctrl_q;
  logic [CNT_W-1:0]      bubble_cnt_d, bubble_cnt_q;
  logic [SUM_W-1:0]      cnt_sum_s;
  logic [OCC_W-1:0]      occ_s;

  // A stall anywhere downstream freezes every stage above it.
  always_comb begin
    hold_s = {STAGES{1'b0}};
    hold_s[STAGES-1] = stall[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      hold_s[i] = stall[i] | hold_s[i+1];
    end
  end

  // Shifted-by-one views give stage i direct access to stage i-1 without negative indices.
  assign hold_ext_s  = {hold_s, 1'b0};
  assign valid_ext_s = {valid_q, 1'b0};
  assign ctrl_ext_s  = {ctrl_q, {W{1'b0}}};

  always_comb begin
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    bubble_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i]) begin
        valid_d[i]       = 1'b0;
        ctrl_d[i*W +: W] = {W{1'b0}};
      end else if (hold_s[i]) begin
        valid_d[i]       = valid_q[i];
        ctrl_d[i*W +: W] = ctrl_q[i*W +: W];
      end else if (i == 0) begin
        valid_d[i]       = in_valid;
        ctrl_d[i*W +: W] = in_valid ? (in_ctrl & KEEP_MASK[i*W +: W]) : {W{1'b0}};
      end else if (hold_ext_s[i]) begin
        valid_d[i]       = 1'b0;
        ctrl_d[i*W +: W] = {W{1'b0}};
        bubble_s[i]      = 1'b1;
      end else begin
        valid_d[i]       = valid_ext_s[i];
        ctrl_d[i*W +: W] = ctrl_ext_s[i*W +: W] & KEEP_MASK[i*W +: W];
      end
    end
  end

  // Extra headroom bits let the per-cycle increment be compared against the ceiling.
  always_comb begin
    cnt_sum_s = {{4{1'b0}}, bubble_cnt_q};
    for (int i = 0; i < STAGES; i++) begin
      cnt_sum_s = cnt_sum_s + SUM_W'(bubble_s[i]);
    end
    if (cnt_sum_s > CNT_MAX) begin
      bubble_cnt_d = CNT_MAX[CNT_W-1:0];
    end else begin
      bubble_cnt_d = cnt_sum_s[CNT_W-1:0];
    end
  end

  always_comb begin
    occ_s = {OCC_W{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      occ_s = occ_s + OCC_W'(valid_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= {STAGES{1'b0}};
      ctrl_q       <= {STAGES*W{1'b0}};
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign in_ready   = ~hold_s[0];
  assign out_valid  = valid_q;
  assign out_ctrl   = ctrl_q;
  assign occupancy  = occ_s;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Table-driven bench for ctrl_pipe_chain: one instance with the default keep mask,
// one with a narrowing mask and a 2-bit bubble counter for saturation.
module tb_ctrl_pipe_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_in_valid, a_in_ready;
  logic [7:0]  a_in_ctrl;
  logic [2:0]  a_stall, a_flush, a_out_valid;
  logic [23:0] a_out_ctrl;
  logic [1:0]  a_occupancy;
  logic [15:0] a_bubble_cnt;

  logic        b_rst, b_in_valid, b_in_ready;
  logic [7:0]  b_in_ctrl;
  logic [2:0]  b_stall, b_flush, b_out_valid;
  logic [23:0] b_out_ctrl;
  logic [1:0]  b_occupancy;
  logic [1:0]  b_bubble_cnt;

  ctrl_pipe_chain #(.W(8), .STAGES(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ctrl(a_in_ctrl),
    .stall(a_stall), .flush(a_flush), .in_ready(a_in_ready), .out_ctrl(a_out_ctrl),
    .out_valid(a_out_valid), .occupancy(a_occupancy), .bubble_cnt(a_bubble_cnt)
  );

  ctrl_pipe_chain #(.W(8), .STAGES(3), .KEEP_MASK(24'h033FFF), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ctrl(b_in_ctrl),
    .stall(b_stall), .flush(b_flush), .in_ready(b_in_ready), .out_ctrl(b_out_ctrl),
    .out_valid(b_out_valid), .occupancy(b_occupancy), .bubble_cnt(b_bubble_cnt)
  );

  typedef struct {
    logic        sel;
    logic        rst;
    logic        iv;
    logic [7:0]  ctrl;
    logic [2:0]  stall;
    logic [2:0]  flush;
    logic        rdy;
    logic [2:0]  v;
    logic [23:0] oc;
    logic [15:0] cnt;
  } vec_t;

  typedef struct {
    int          idx;
    logic        sel;
    logic [2:0]  v;
    logic [23:0] oc;
    logic [15:0] cnt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic sel, logic rst, logic iv, logic [7:0] ctrl,
                              logic [2:0] stall, logic [2:0] flush, logic rdy,
                              logic [2:0] v, logic [23:0] oc, logic [15:0] cnt);
    vec_t r;
    r.sel = sel; r.rst = rst; r.iv = iv; r.ctrl = ctrl; r.stall = stall;
    r.flush = flush; r.rdy = rdy; r.v = v; r.oc = oc; r.cnt = cnt;
    return r;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    logic [2:0]  got_v;
    logic [23:0] got_oc;
    logic [15:0] got_cnt;
    logic [1:0]  got_occ;
    logic        got_rdy;

    a_rst = 1'b0; a_in_valid = 1'b0; a_in_ctrl = 8'h00; a_stall = 3'b000; a_flush = 3'b000;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_ctrl = 8'h00; b_stall = 3'b000; b_flush = 3'b000;

    //            sel  rst   iv    ctrl   stall   flush   rdy   valid   ctrl{s2,s1,s0} cnt
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 24'h000000, 16'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h11, 3'b000, 3'b000, 1'b1, 3'b001, 24'h000011, 16'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h22, 3'b000, 3'b000, 1'b1, 3'b011, 24'h001122, 16'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h33, 3'b000, 3'b000, 1'b1, 3'b111, 24'h112233, 16'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h44, 3'b010, 3'b000, 1'b0, 3'b011, 24'h002233, 16'd1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h44, 3'b010, 3'b000, 1'b0, 3'b011, 24'h002233, 16'd2));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h44, 3'b000, 3'b000, 1'b1, 3'b111, 24'h223344, 16'd2));
    // stall[0]+flush[0]: stage 0 clears, stage 1 still takes a counted bubble
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h55, 3'b001, 3'b001, 1'b0, 3'b100, 24'h330000, 16'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'hFF, 3'b000, 3'b000, 1'b1, 3'b000, 24'h000000, 16'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h66, 3'b000, 3'b000, 1'b1, 3'b001, 24'h000066, 16'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h77, 3'b001, 3'b010, 1'b0, 3'b001, 24'h000066, 16'd3));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h77, 3'b010, 3'b010, 1'b0, 3'b001, 24'h000066, 16'd4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h77, 3'b000, 3'b000, 1'b1, 3'b011, 24'h006677, 16'd4));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h88, 3'b100, 3'b000, 1'b0, 3'b011, 24'h006677, 16'd4));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 8'h88, 3'b111, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'h99, 3'b000, 3'b000, 1'b1, 3'b001, 24'h000099, 16'd0));
    // narrowing mask and 2-bit saturating counter
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b000, 24'h000000, 16'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'hFF, 3'b000, 3'b000, 1'b1, 3'b001, 24'h0000FF, 16'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b010, 24'h003F00, 16'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00, 3'b000, 3'b000, 1'b1, 3'b100, 24'h030000, 16'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'h12, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd1));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'h12, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd2));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'h12, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd3));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'h12, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd3));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'h12, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd3));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 8'h12, 3'b001, 3'b000, 1'b0, 3'b000, 24'h000000, 16'd0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b1, 8'h5A, 3'b000, 3'b000, 1'b1, 3'b001, 24'h00005A, 16'd0));

    @(posedge clk);
    #1;
    for (int k = 0; k < tbl.size(); k++) begin
      if (tbl[k].sel == 1'b0) begin
        a_rst = tbl[k].rst; a_in_valid = tbl[k].iv; a_in_ctrl = tbl[k].ctrl;
        a_stall = tbl[k].stall; a_flush = tbl[k].flush;
      end else begin
        b_rst = tbl[k].rst; b_in_valid = tbl[k].iv; b_in_ctrl = tbl[k].ctrl;
        b_stall = tbl[k].stall; b_flush = tbl[k].flush;
      end
      #1;
      got_rdy = (tbl[k].sel == 1'b0) ? a_in_ready : b_in_ready;
      chk("in_ready", k, {31'd0, got_rdy}, {31'd0, tbl[k].rdy});

      e.idx = k; e.sel = tbl[k].sel; e.v = tbl[k].v; e.oc = tbl[k].oc; e.cnt = tbl[k].cnt;
      sb.push_back(e);

      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (e.sel == 1'b0) begin
        got_v = a_out_valid; got_oc = a_out_ctrl; got_cnt = a_bubble_cnt; got_occ = a_occupancy;
      end else begin
        got_v = b_out_valid; got_oc = b_out_ctrl; got_cnt = {14'd0, b_bubble_cnt};
        got_occ = b_occupancy;
      end
      chk("out_valid", e.idx, {29'd0, got_v}, {29'd0, e.v});
      chk("out_ctrl", e.idx, {8'd0, got_oc}, {8'd0, e.oc});
      chk("bubble_cnt", e.idx, {16'd0, got_cnt}, {16'd0, e.cnt});
      chk("occupancy", e.idx, {30'd0, got_occ}, 32'($countones(e.v)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
